// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// default memory timeout and counter limits.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } ctrlState_e;

  localparam logic [7:0]  DEFAULT_TIMEOUT = 8'd255;
  localparam logic [15:0] STALL_CNT_MAX   = 16'hFFFF;
  localparam logic [4:0]  REG_ZERO        = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: a load in ID/EX whose destination
// (other than the hard-wired zero register) feeds either IF/ID source.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       memRead,
  input  logic [4:0] exRegRt,
  input  logic [4:0] idRegRs,
  input  logic [4:0] idRegRt,
  output logic       hazard
);

  assign hazard = memRead && (exRegRt != REG_ZERO) &&
                  ((exRegRt == idRegRs) || (exRegRt == idRegRt));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data-memory wait FSM with timeout, load-use
// bubbling, branch flushing and a saturating stall-cycle counter.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        IE_MemRead_i,
  input  logic [4:0]  IE_RegRT_i,
  input  logic [4:0]  ID_RegRS_i,
  input  logic [4:0]  ID_RegRT_i,
  input  logic        Branch_taken_i,
  input  logic        EM_MemReq_i,
  input  logic        Mem_ack_i,
  output logic        Mem_start_o,
  output logic        PC_Write_o,
  output logic        IFID_Write_o,
  output logic        IFID_Flush_o,
  output logic        IDEX_Bubble_o,
  output logic        Pipe_Stall_o,
  output logic        Mem_err_o,
  output logic [15:0] Stall_cnt_o
);

  ctrlState_e  stateReg, stateNext;
  logic [7:0]  waitCntReg, waitCntNext;
  logic        memErrReg, memErrNext;
  logic [15:0] stallCntReg, stallCntNext;
  logic        loadUse;
  logic        memStart, pipeStall, pcWrite, ifidWrite, ifidFlush, idexBubble;

  load_use_detect u_loadUse (
    .memRead (IE_MemRead_i),
    .exRegRt (IE_RegRT_i),
    .idRegRs (ID_RegRS_i),
    .idRegRt (ID_RegRT_i),
    .hazard  (loadUse)
  );

  always_comb begin
    stateNext    = stateReg;
    waitCntNext  = waitCntReg;
    memErrNext   = memErrReg;
    memStart     = 1'b0;
    pipeStall    = 1'b0;
    pcWrite      = 1'b1;
    ifidWrite    = 1'b1;
    ifidFlush    = 1'b0;
    idexBubble   = 1'b0;
    stallCntNext = stallCntReg;

    case (stateReg)
      RUN: begin
        if (EM_MemReq_i) begin
          memStart    = 1'b1;
          pipeStall   = 1'b1;
          waitCntNext = 8'd0;
          stateNext   = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        pipeStall   = 1'b1;
        waitCntNext = waitCntReg + 8'd1;
        // Ack wins over a simultaneous timeout, leaving the error flag alone.
        if (Mem_ack_i) begin
          stateNext = MEM_DONE;
        end else if (waitCntNext == TIMEOUT) begin
          memErrNext = 1'b1;
          stateNext  = MEM_DONE;
        end
      end
      MEM_DONE: stateNext = RUN;
      default:  stateNext = RUN;
    endcase

    if (pipeStall) begin
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
    end else if (loadUse) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
    end else if (Branch_taken_i) begin
      ifidFlush = 1'b1;
    end

    if (rst_i) begin
      memStart   = 1'b0;
      pipeStall  = 1'b0;
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      ifidFlush  = 1'b0;
      idexBubble = 1'b0;
    end

    if ((pipeStall || idexBubble) && (stallCntReg != STALL_CNT_MAX)) begin
      stallCntNext = stallCntReg + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stateReg    <= RUN;
      waitCntReg  <= 8'd0;
      memErrReg   <= 1'b0;
      stallCntReg <= 16'd0;
    end else begin
      stateReg    <= stateNext;
      waitCntReg  <= waitCntNext;
      memErrReg   <= memErrNext;
      stallCntReg <= stallCntNext;
    end
  end

  assign Mem_start_o   = memStart;
  assign Pipe_Stall_o  = pipeStall;
  assign PC_Write_o    = pcWrite;
  assign IFID_Write_o  = ifidWrite;
  assign IFID_Flush_o  = ifidFlush;
  assign IDEX_Bubble_o = idexBubble;
  assign Mem_err_o     = memErrReg;
  assign Stall_cnt_o   = stallCntReg;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd255: max MEM_WAIT cycles before abort.
REQ-002 SHALL have port clk_i  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port IE_MemRead_i  input  1  ID/EX instruction is a load.
REQ-005 SHALL have port IE_RegRT_i  input  5  ID/EX load destination register.
REQ-006 SHALL have port ID_RegRS_i, ID_RegRT_i  input  5 each  IF/ID source registers.
REQ-007 SHALL have port Branch_taken_i  input  1  branch resolved taken in ID.
REQ-008 SHALL have port EM_MemReq_i  input  1  EX/MEM instruction accesses data memory.
REQ-009 SHALL have port Mem_ack_i  input  1  data memory access complete (one-cycle pulse).
REQ-010 SHALL have port Mem_start_o  output  1  one-cycle pulse starting a memory access.
REQ-011 SHALL have ports PC_Write_o, IFID_Write_o  output  1 each  enable for PC and IF/ID registers.
REQ-012 SHALL have ports IFID_Flush_o, IDEX_Bubble_o  output  1 each  zero IF/ID; insert NOP into ID/EX.
REQ-013 SHALL have port Pipe_Stall_o  output  1  freezes IDEX, EXMEM and MEMWB registers.
REQ-014 SHALL have port Mem_err_o  output  1  sticky timeout flag.
REQ-015 SHALL have port Stall_cnt_o  output  16  saturating count of stalled cycles.

Function
REQ-016 SHALL implement FSM with states RUN, MEM_WAIT and MEM_DONE.
REQ-017 In RUN with EM_MemReq_i=1, SHALL assert Mem_start_o and Pipe_Stall_o that cycle and go to MEM_WAIT.
REQ-018 In MEM_WAIT, SHALL hold Pipe_Stall_o=1, PC_Write_o=0, IFID_Write_o=0 and increment an 8-bit wait counter each cycle.
REQ-019 In MEM_WAIT on Mem_ack_i=1, SHALL go to MEM_DONE; ack in RUN or MEM_DONE SHALL be ignored.
REQ-020 In MEM_WAIT when wait counter reaches TIMEOUT without ack, SHALL set Mem_err_o and go to MEM_DONE.
REQ-021 In MEM_DONE, SHALL deassert Pipe_Stall_o, never pulse Mem_start_o, and return to RUN next cycle, so a served instruction is never re-issued.
REQ-022 Ack and timeout in the same cycle SHALL take the ack path; Mem_err_o stays unchanged.
REQ-023 Load-use hazard = IE_MemRead_i & IE_RegRT_i!=0 & (IE_RegRT_i==ID_RegRS_i | IE_RegRT_i==ID_RegRT_i).
REQ-024 In any cycle where Pipe_Stall_o=0, load-use SHALL give PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=1.
REQ-025 Branch_taken_i with no load-use and Pipe_Stall_o=0 SHALL give IFID_Flush_o=1, PC_Write_o=1.
REQ-026 Priority SHALL be: memory stall > load-use > branch flush; lower-priority outputs are suppressed.
REQ-027 While Pipe_Stall_o=1, IDEX_Bubble_o and IFID_Flush_o SHALL be 0.
REQ-028 With no hazard, PC_Write_o=IFID_Write_o=1 and all other control outputs SHALL be 0.
REQ-029 Stall_cnt_o SHALL increment each cycle with Pipe_Stall_o|IDEX_Bubble_o and SHALL saturate at 16'hFFFF.
REQ-030 Combinational outputs SHALL depend on state and current inputs only; FSM, wait counter, Mem_err_o and Stall_cnt_o are registered.

Reset
REQ-031 While rst_i=1 at a clock edge, SHALL set state RUN, wait counter 0, Mem_err_o=0, Stall_cnt_o=0.
REQ-032 Reset asserted in MEM_WAIT SHALL abandon the access; there is no Mem_start_o in the following cycle unless EM_MemReq_i=1 after reset is released.
REQ-033 Outputs while rst_i=1 SHALL be PC_Write_o=0, IFID_Write_o=0, all others 0.

Structure
REQ-034 State encoding (2-bit RUN/MEM_WAIT/MEM_DONE) and the default TIMEOUT SHALL live in shared package pipe_ctrl_pkg.
REQ-035 The load-use comparator SHALL be the sub-module load_use_detect (purely combinational); the FSM and counters stay in hazard_ctrl.

Verification
REQ-036 IE_MemRead_i=1, IE_RegRT_i=5'd8, ID_RegRS_i=5'd8 -> one cycle with PC_Write_o=0, IDEX_Bubble_o=1, Stall_cnt_o +1.
REQ-037 IE_RegRT_i=0 matching ID_RegRS_i=0 with load -> no stall; Branch_taken_i=1 alone -> IFID_Flush_o=1 for one cycle.
REQ-038 EM_MemReq_i=1, ack 3 cycles after start -> Mem_start_o pulses once; Pipe_Stall_o high 4 cycles; MEM_DONE with stall 0; no second start.
REQ-039 TIMEOUT=4, no ack -> Mem_err_o=1 after 4 wait cycles, stays set; ack on timeout cycle -> Mem_err_o stays 0.
REQ-040 Load-use + Branch_taken_i during MEM_WAIT -> only Pipe_Stall_o; after MEM_DONE, bubble has priority and flush is suppressed.
REQ-041 rst_i mid-MEM_WAIT -> state RUN, counters 0; Stall_cnt_o forced to 16'hFFFE and 3 stalls -> holds 16'hFFFF.
